flash_pixel_packer: RTL and testbench
=====================================

// Module: flash_pixel_packer
// PURPOSE
//  Stage directly downstream of the SPI flash image reader. Consumes the reader's one-byte strobes.
//  Packs each 3 consecutive bytes into a 24-bit RGB pixel and tags pixels with frame geometry (SOF/EOL).
//  Buffers pixels in a small FIFO, so the pixel consumer (frame writer / GMII payload builder) may backpressure.
//  The flash stream itself cannot stall: a full FIFO drops the pixel and raises a sticky overflow flag.
// PARAMETERS
//  IMG_W       480  pixels per line
//  IMG_H       272  lines per frame
//  FIFO_DEPTH  4    pixel FIFO entries; power of two, >=2
// PORTS
//  clock        in   1   single clock; all logic on posedge
//  flash_rst    in   1   synchronous, active-high reset
//  byte_i       in   8   image byte from flash reader
//  byte_valid_i in   1   one-cycle strobe, byte_i valid
//  flash_done_i in   1   level: flash reader finished frame
//  pix_o        out  24  pixel {R,G,B}; first byte of triplet -> [23:16]
//  pix_sof_o    out  1   pixel is x=0,y=0
//  pix_eol_o    out  1   pixel is x=IMG_W-1
//  pix_valid_o  out  1   FIFO head valid
//  pix_ready_i  in   1   consumer accepts head when valid&ready
//  frame_done_o out  1   sticky: last pixel (IMG_W*IMG_H-th) popped
//  overflow_o   out  1   sticky: pixel dropped, FIFO full
//  short_frame_o out 1   sticky: flash_done_i rose before full frame assembled
// BEHAVIOUR
//  Reset: every output 0; byte phase=0; x=y=0; FIFO empty; all stickies cleared. Applies at any time, incl. mid-frame.
//  Byte phase 0->1->2->0, advancing on byte_valid_i. Phases 0 and 1 hold their bytes in registers.
//  Phase 2 strobe at edge N: pixel = {b0,b1,byte_i} is written to the FIFO at edge N. pix_valid_o is high in cycle N+1 when the FIFO was empty (FWFT).
//  Geometry counters x,y advance per assembled pixel, whether it is pushed or dropped. x wraps at IMG_W-1; y increments on x wrap.
//  sof/eol are stored with the pixel in the FIFO.
//  Pixel count reaches IMG_W*IMG_H: packer enters FULL state. Further bytes are ignored, with no flag and no push. Counters hold.
//  FIFO pop on pix_valid_o&pix_ready_i. Push and pop in the same cycle is legal at any fill, including full.
//  Push while full without a pop: pixel dropped; overflow_o<=1.
//  frame_done_o<=1 on the pop of the pixel with x=IMG_W-1 and y=IMG_H-1.
//  flash_done_i rising edge while not FULL, or with byte phase!=0: short_frame_o<=1. Partial bytes are discarded.
//  States: IDLE (no byte yet) -> PACK (first strobe) -> FULL (last pixel assembled). Exit from FULL only via reset.
//  Counter widths: $clog2(IMG_W), $clog2(IMG_H). FIFO ptrs: $clog2(FIFO_DEPTH)+1 bits (wrap bit).
// CONFIGURATION
//  PIXEL_RGB565_EN defined: pix_o[15:0]={R[7:3],G[7:2],B[7:3]}; pix_o[23:16]=0. FIFO data stores 16 bits.
//  Not defined: full 24-bit RGB888 as above. Timing and flags are identical in both builds.
// STRUCTURE
//  Shared package/header: IMG_W/IMG_H defaults; packer state encodings IDLE/PACK/FULL; pixel word width macro (24 or 16).
//  Sub-module pix_fifo: synchronous FWFT FIFO, parameters WIDTH and DEPTH.
//    Ports: wr_en, din, full, rd_en, dout, empty.
//    Behaviour: wr_en&full&!rd_en ignored. Simultaneous rd/wr when full is permitted.
//  Packer FSM, byte registers, x/y counters and sticky flags live in flash_pixel_packer.
// TESTING
//  1) Bytes 11,22,33 at 8-cycle spacing, ready=1 -> pix_o=112233, sof=1, valid exactly 1 cycle after 3rd strobe.
//  2) Full 480x272 frame (391680 bytes), ready=1 -> 130560 pixels. eol on every 480th pixel.
//     frame_done_o after last pop; overflow_o=0, short_frame_o=0.
//  3) ready=0 over 6 pixels, DEPTH=4 -> 4 held, 2 dropped, overflow_o=1. x/y still advance 6; next pops are pixels 0..3.
//  4) FIFO full, push and pop in the same cycle -> no drop, occupancy stays 4, overflow_o stays 0.
//  5) flash_done_i rises after 4 bytes -> short_frame_o=1; byte 4 discarded; no FIFO push.
//  6) flash_rst mid-frame (pixel 100, phase 1) -> all outputs 0 next cycle. Next 3 bytes give pixel with sof=1.
//  7) Build with PIXEL_RGB565_EN, bytes FF,80,08 -> pix_o=00FC01.

Source files
------------

// File: rtl/flash_pixel_packer_pkg.sv
// rtl/flash_pixel_packer_pkg.sv - shared constants, packer states and pixel packing helper
//
// Purpose: default frame geometry, the packer state encoding and the stored
// pixel word width. The pixel word is 24 bits (RGB888) by default, or 16 bits
// (RGB565) when PIXEL_RGB565_EN is defined.
package flash_pixel_packer_pkg;

  localparam int IMG_W_DEF      = 480;
  localparam int IMG_H_DEF      = 272;
  localparam int FIFO_DEPTH_DEF = 4;

`ifdef PIXEL_RGB565_EN
  localparam int PIX_W = 16;
`else
  localparam int PIX_W = 24;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_FULL = 2'd2
  } pack_state_e;

  // First byte of a triplet is red, then green, then blue.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
`ifdef PIXEL_RGB565_EN
    return {r[7:3], g[7:2], b[7:3]};
`else
    return {r, g, b};
`endif
  endfunction

endpackage

// File: rtl/flash_pixel_packer_pix_fifo.sv
// rtl/flash_pixel_packer_pix_fifo.sv - synchronous first-word-fall-through pixel FIFO
//
// Purpose: small FWFT FIFO; dout shows the head entry whenever empty is low.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   wr_en, din   push request and data; a push while full is accepted only
//                when a pop happens in the same cycle
//   full         all DEPTH entries occupied
//   rd_en        pop request; ignored while empty
//   dout, empty  head entry and empty status
module pix_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    // Pointers carry an extra wrap bit: equal index, different lap means full.
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd = rd_en && !empty;
    // When full, a concurrent pop frees the slot the push lands in.
    do_wr = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/flash_pixel_packer.sv
// rtl/flash_pixel_packer.sv - packs flash bytes into tagged RGB pixels behind a small FIFO
//
// Purpose: assembles every three byte strobes into one pixel, tags it with
// start-of-frame / end-of-line, and queues it for a consumer that may stall.
// The byte stream cannot stall, so a push into a full FIFO drops the pixel.
// Build option: PIXEL_RGB565_EN selects RGB565 output in pix_o[15:0].
// Ports:
//   clock, flash_rst           clock and synchronous active-high reset
//   byte_i, byte_valid_i       byte strobe from the flash reader
//   flash_done_i               level, reader finished the frame
//   pix_o, pix_sof_o, pix_eol_o  FIFO head pixel and its tags (0 when empty)
//   pix_valid_o, pix_ready_i   head valid / consumer accept
//   frame_done_o               sticky, last pixel of the frame popped
//   overflow_o                 sticky, a pixel was dropped
//   short_frame_o              sticky, reader finished before a full frame
module flash_pixel_packer
  import flash_pixel_packer_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        flash_rst,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        flash_done_i,
  output logic [23:0] pix_o,
  output logic        pix_sof_o,
  output logic        pix_eol_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        frame_done_o,
  output logic        overflow_o,
  output logic        short_frame_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  // FIFO entry: {last_of_frame, sof, eol, pixel}
  localparam int FW = PIX_W + 3;

  pack_state_e state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          done_seen_q, done_seen_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          short_q, short_d;

  logic          done_rise, accept, pix_push, at_last, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_din, fifo_dout;

  always_comb begin
    done_rise = flash_done_i && !done_seen_q;
    // A finish edge discards the partial triplet, so a coincident byte is dropped too.
    accept    = byte_valid_i && (state_q != ST_FULL) && !done_rise;
    pix_push  = accept && (phase_q == 2'd2);
    at_last   = (x_q == X_LAST) && (y_q == Y_LAST);
    fifo_pop  = !fifo_empty && pix_ready_i;
    fifo_din  = {at_last, (x_q == '0) && (y_q == '0), (x_q == X_LAST),
                 pack_pixel(b0_q, b1_q, byte_i)};

    state_d      = state_q;
    phase_d      = phase_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    x_d          = x_q;
    y_d          = y_q;
    done_seen_d  = flash_done_i;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    short_d      = short_q;

    if (done_rise && ((state_q != ST_FULL) || (phase_q != 2'd0))) begin
      short_d = 1'b1;
      phase_d = 2'd0;
    end

    if (accept) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_PACK;
      end
      case (phase_q)
        2'd0:    begin b0_d = byte_i; phase_d = 2'd1; end
        2'd1:    begin b1_d = byte_i; phase_d = 2'd2; end
        default: phase_d = 2'd0;
      endcase
    end

    // Geometry advances for every assembled pixel, even one that is dropped.
    if (pix_push) begin
      if (fifo_full && !fifo_pop) begin
        overflow_d = 1'b1;
      end
      if (at_last) begin
        state_d = ST_FULL;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (fifo_pop && fifo_dout[FW-1]) begin
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (flash_rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 2'd0;
      b0_q         <= 8'd0;
      b1_q         <= 8'd0;
      x_q          <= '0;
      y_q          <= '0;
      done_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      x_q          <= x_d;
      y_q          <= y_d;
      done_seen_q  <= done_seen_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      short_q      <= short_d;
    end
  end

  pix_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk   (clock),
    .rst   (flash_rst),
    .wr_en (pix_push),
    .din   (fifo_din),
    .full  (fifo_full),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero when the FIFO is empty so stale storage never shows.
  always_comb begin
    pix_valid_o = !fifo_empty;
    pix_o       = '0;
    pix_sof_o   = 1'b0;
    pix_eol_o   = 1'b0;
    if (pix_valid_o) begin
      pix_o     = 24'(fifo_dout[PIX_W-1:0]);
      pix_sof_o = fifo_dout[PIX_W+1];
      pix_eol_o = fifo_dout[PIX_W];
    end
    frame_done_o  = frame_done_q;
    overflow_o    = overflow_q;
    short_frame_o = short_q;
  end

endmodule

// File: tb/tb_flash_pixel_packer.sv
// tb/tb_flash_pixel_packer.sv - directed self-checking bench for flash_pixel_packer
module tb_flash_pixel_packer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        flash_rst;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        flash_done_i;
  logic [23:0] pix_o;
  logic        pix_sof_o;
  logic        pix_eol_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic        frame_done_o;
  logic        overflow_o;
  logic        short_frame_o;

  int errors = 0;
  int checks = 0;
  logic [25:0] popq[$];

  always #5 clock = ~clock;

  flash_pixel_packer #(
    .IMG_W      (W),
    .IMG_H      (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clock         (clock),
    .flash_rst     (flash_rst),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .flash_done_i  (flash_done_i),
    .pix_o         (pix_o),
    .pix_sof_o     (pix_sof_o),
    .pix_eol_o     (pix_eol_o),
    .pix_valid_o   (pix_valid_o),
    .pix_ready_i   (pix_ready_i),
    .frame_done_o  (frame_done_o),
    .overflow_o    (overflow_o),
    .short_frame_o (short_frame_o)
  );

  // Records every pop; inputs change 2 ns after posedge so they are stable here.
  always @(negedge clock) begin
    if (!flash_rst && pix_valid_o && pix_ready_i) begin
      popq.push_back({pix_sof_o, pix_eol_o, pix_o});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
`ifdef PIXEL_RGB565_EN
    return {8'h00, r[7:3], g[7:2], b[7:3]};
`else
    return {r, g, b};
`endif
  endfunction

  function automatic logic [7:0] pbyte(input int k, input int i);
    case (i)
      0:       return 8'(k);
      1:       return 8'(k + 8'h40);
      default: return 8'(8'hF0 - k);
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int k, input logic sof, input logic eol);
    return {6'd0, sof, eol, exp_pix(pbyte(k, 0), pbyte(k, 1), pbyte(k, 2))};
  endfunction

  // Strobe sampled at the next posedge; returns 2 ns after that edge.
  task automatic send_byte(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_pix(input int k);
    for (int i = 0; i < 3; i++) begin
      send_byte(pbyte(k, i));
      tick();
    end
  endtask

  task automatic do_reset();
    flash_rst    = 1'b1;
    byte_valid_i = 1'b0;
    flash_done_i = 1'b0;
    pix_ready_i  = 1'b0;
    tick(2);
    flash_rst = 1'b0;
    popq.delete();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix"}, 32'(pix_o), 32'h0);
    check({tag, "_valid"}, 32'(pix_valid_o), 32'h0);
    check({tag, "_sofeol"}, {30'd0, pix_sof_o, pix_eol_o}, 32'h0);
    check({tag, "_stickies"}, {29'd0, frame_done_o, overflow_o, short_frame_o}, 32'h0);
  endtask

  initial begin
    flash_rst    = 1'b1;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    flash_done_i = 1'b0;
    pix_ready_i  = 1'b0;

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Single pixel, 8-cycle spacing, FWFT latency
    pix_ready_i = 1'b1;
    send_byte(8'h11); tick(7);
    send_byte(8'h22); tick(7);
    check("t1_no_valid_early", 32'(pix_valid_o), 32'h0);
    send_byte(8'h33);
    check("t1_valid", 32'(pix_valid_o), 32'h1);
    check("t1_pix", 32'(pix_o), 32'(exp_pix(8'h11, 8'h22, 8'h33)));
    check("t1_sof", 32'(pix_sof_o), 32'h1);
    check("t1_eol", 32'(pix_eol_o), 32'h0);
    tick();
    check("t1_valid_one_cycle", 32'(pix_valid_o), 32'h0);

    // Whole frame: sof/eol placement, frame_done timing, FULL ignores input
    do_reset();
    pix_ready_i = 1'b1;
    for (int k = 0; k < W * H - 1; k++) send_pix(k);
    send_byte(pbyte(W * H - 1, 0)); tick();
    send_byte(pbyte(W * H - 1, 1)); tick();
    send_byte(pbyte(W * H - 1, 2));
    check("t2_done_before_pop", 32'(frame_done_o), 32'h0);
    tick();
    check("t2_done_after_pop", 32'(frame_done_o), 32'h1);
    tick(2);
    check("t2_count", 32'(popq.size()), 32'(W * H));
    for (int k = 0; k < W * H; k++) begin
      if (k < popq.size())
        check($sformatf("t2_pix%0d", k), 32'(popq[k]),
              exp_word(k, k == 0, (k % W) == W - 1));
    end
    check("t2_overflow", 32'(overflow_o), 32'h0);
    check("t2_short", 32'(short_frame_o), 32'h0);
    send_pix(5);
    tick(3);
    check("t2_full_ignores", 32'(popq.size()), 32'(W * H));
    check("t2_full_no_valid", 32'(pix_valid_o), 32'h0);
    flash_done_i = 1'b1;
    tick(2);
    check("t2_done_in_full", 32'(short_frame_o), 32'h0);
    flash_done_i = 1'b0;

    // Overflow: 6 pixels against a stalled consumer
    do_reset();
    for (int k = 0; k < 4; k++) send_pix(k);
    check("t3_no_ovf_at_4", 32'(overflow_o), 32'h0);
    check("t3_valid", 32'(pix_valid_o), 32'h1);
    send_pix(4);
    check("t3_ovf_at_5", 32'(overflow_o), 32'h1);
    send_pix(5);
    pix_ready_i = 1'b1;
    tick(6);
    check("t3_held", 32'(popq.size()), 32'h4);
    for (int k = 0; k < 4; k++) begin
      if (k < popq.size())
        check($sformatf("t3_pix%0d", k), 32'(popq[k]), exp_word(k, k == 0, 1'b0));
    end
    send_pix(6);
    send_pix(7);
    tick(2);
    check("t3_count", 32'(popq.size()), 32'h6);
    if (popq.size() == 6) begin
      check("t3_x6", 32'(popq[4]), exp_word(6, 1'b0, 1'b0));
      check("t3_x7_eol", 32'(popq[5]), exp_word(7, 1'b0, 1'b1));
    end

    // Push and pop together while full
    do_reset();
    for (int k = 0; k < 4; k++) send_pix(k);
    send_byte(pbyte(4, 0)); tick();
    send_byte(pbyte(4, 1)); tick();
    byte_i       = pbyte(4, 2);
    byte_valid_i = 1'b1;
    pix_ready_i  = 1'b1;
    tick();
    byte_valid_i = 1'b0;
    pix_ready_i  = 1'b0;
    tick();
    check("t4_no_ovf", 32'(overflow_o), 32'h0);
    check("t4_one_popped", 32'(popq.size()), 32'h1);
    pix_ready_i = 1'b1;
    tick(6);
    check("t4_count", 32'(popq.size()), 32'h5);
    if (popq.size() == 5) begin
      check("t4_first", 32'(popq[0]), exp_word(0, 1'b1, 1'b0));
      check("t4_last", 32'(popq[4]), exp_word(4, 1'b0, 1'b0));
    end
    check("t4_ovf_final", 32'(overflow_o), 32'h0);

    // Short frame: finish after 4 bytes
    do_reset();
    pix_ready_i = 1'b1;
    send_pix(0);
    send_byte(8'h77); tick();
    flash_done_i = 1'b1;
    tick(3);
    check("t5_short", 32'(short_frame_o), 32'h1);
    check("t5_no_push", 32'(popq.size()), 32'h1);
    send_pix(1);
    tick(2);
    check("t5_count", 32'(popq.size()), 32'h2);
    if (popq.size() == 2)
      check("t5_realigned", 32'(popq[1]), exp_word(1, 1'b0, 1'b0));
    flash_done_i = 1'b0;

    // Reset mid-frame at pixel 10, phase 1
    do_reset();
    for (int k = 0; k < 10; k++) send_pix(k);
    send_byte(8'hAB); tick();
    check("t6_pre_ovf", 32'(overflow_o), 32'h1);
    flash_rst = 1'b1;
    tick();
    check_all_zero("t6");
    flash_rst = 1'b0;
    popq.delete();
    pix_ready_i = 1'b1;
    send_byte(8'h5A); tick();
    send_byte(8'hC3); tick();
    send_byte(8'h0F);
    check("t6_valid", 32'(pix_valid_o), 32'h1);
    check("t6_sof", 32'(pix_sof_o), 32'h1);
    check("t6_pix", 32'(pix_o), 32'(exp_pix(8'h5A, 8'hC3, 8'h0F)));

    // Colour format boundary bytes
    do_reset();
    pix_ready_i = 1'b1;
    send_byte(8'hFF); tick();
    send_byte(8'h80); tick();
    send_byte(8'h08);
`ifdef PIXEL_RGB565_EN
    check("t7_pix", 32'(pix_o), 32'h0000FC01);
`else
    check("t7_pix", 32'(pix_o), 32'h00FF8008);
`endif
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
